// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg (package)
// Description : Shared constants and types for the MIPS inter-stage pipeline
//               registers. Holds the default exception-handler PC, default
//               exception-code width, the NOP encoding, the ExcCode values
//               and the per-edge priority-select type.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
  localparam int          DEF_EXC_W      = 5;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

  // ExcCode values (CP0 Cause.ExcCode encoding)
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Action taken by a stage register on a clock edge, highest priority first
  typedef enum logic [1:0] {
    SEL_FLUSH = 2'd0,
    SEL_HOLD  = 2'd1,
    SEL_STALL = 2'd2,
    SEL_LOAD  = 2'd3
  } sel_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf_cnt
// Description : Saturating event counter. Increments once per enabled clock
//               edge and sticks at all-ones; cleared only by reset.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous reset, active low
//               i_en    - count this edge
//               o_cnt   - current count [CNT_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule : pipe_perf_cnt
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised inter-stage pipeline register (D/E, E/M, M/W).
//               Carries instruction, PC, NUM_OPS operand words, exception
//               code, branch-delay flag and a valid bit. Per-edge priority is
//               flush > hold > stall > load. A faulting instruction is
//               squashed to NOP on load while its PC and ExcCode travel on.
// Ports       : clk, reset (async, active low)
//               stall, hold, flush         - stage control
//               d_valid/instr/pc/ops/exc/bd - upstream slot
//               q_valid/instr/pc/ops/exc/bd - registered slot
//               bubble_cnt, flush_cnt      - performance counters
// Option      : PIPE_STAGE_PERF_CNT_EN - when defined, bubble_cnt/flush_cnt
//               are saturating counters; otherwise both are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              PC_W       = 32,
  parameter int              NUM_OPS    = 2,
  parameter int              EXC_W      = DEF_EXC_W,
  parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(DEF_HANDLER_PC),
  parameter int              CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      hold,
  input  logic                      flush,
  input  logic                      d_valid,
  input  logic [DATA_W-1:0]         d_instr,
  input  logic [PC_W-1:0]           d_pc,
  input  logic [NUM_OPS*DATA_W-1:0] d_ops,
  input  logic [EXC_W-1:0]          d_exc,
  input  logic                      d_bd,
  output logic                      q_valid,
  output logic [DATA_W-1:0]         q_instr,
  output logic [PC_W-1:0]           q_pc,
  output logic [NUM_OPS*DATA_W-1:0] q_ops,
  output logic [EXC_W-1:0]          q_exc,
  output logic                      q_bd,
  output logic [CNT_W-1:0]          bubble_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  logic                      r_valid;
  logic [DATA_W-1:0]         r_instr;
  logic [PC_W-1:0]           r_pc;
  logic [NUM_OPS*DATA_W-1:0] r_ops;
  logic [EXC_W-1:0]          r_exc;
  logic                      r_bd;

  sel_e              w_sel;
  logic [DATA_W-1:0] w_instr_ld;

  always_comb begin
    w_sel = SEL_LOAD;
    if (flush) begin
      w_sel = SEL_FLUSH;
    end else if (hold) begin
      w_sel = SEL_HOLD;
    end else if (stall) begin
      w_sel = SEL_STALL;
    end
  end

  // Squash: a faulting instruction becomes a NOP so it cannot execute
  // downstream; its PC and ExcCode still reach the exception logic.
  assign w_instr_ld = (d_exc == EXC_W'(EXC_INT)) ? d_instr : DATA_W'(NOP_INSTR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_ops   <= '0;
      r_exc   <= '0;
      r_bd    <= 1'b0;
    end else begin
      case (w_sel)
        SEL_FLUSH: begin
          r_valid <= 1'b0;
          r_instr <= '0;
          r_pc    <= HANDLER_PC;
          r_ops   <= '0;
          r_exc   <= '0;
          r_bd    <= 1'b0;
        end
        SEL_STALL: begin
          // Bubble keeps PC and BD so an EPC derived from it is correct
          r_valid <= 1'b0;
          r_instr <= '0;
          r_pc    <= d_pc;
          r_ops   <= '0;
          r_exc   <= '0;
          r_bd    <= d_bd;
        end
        SEL_LOAD: begin
          r_valid <= d_valid;
          r_instr <= w_instr_ld;
          r_pc    <= d_pc;
          r_ops   <= d_ops;
          r_exc   <= d_exc;
          r_bd    <= d_bd;
        end
        default: begin
          // SEL_HOLD: every register retains its value
        end
      endcase
    end
  end

  assign q_valid = r_valid;
  assign q_instr = r_instr;
  assign q_pc    = r_pc;
  assign q_ops   = r_ops;
  assign q_exc   = r_exc;
  assign q_bd    = r_bd;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic w_bubble_en;
  logic w_flush_en;

  // A bubble is only counted when one is actually inserted
  assign w_bubble_en = (w_sel == SEL_STALL);
  assign w_flush_en  = (w_sel == SEL_FLUSH);

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_bubble_en),
    .o_cnt (bubble_cnt)
  );

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_flush_en),
    .o_cnt (flush_cnt)
  );
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg (NUM_OPS=3, CNT_W=4).
//               A reference model computes the expected slot for each edge
//               and queues it; a monitor compares after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int          DATA_W  = 32;
  localparam int          PC_W    = 32;
  localparam int          NUM_OPS = 3;
  localparam int          EXC_W   = 5;
  localparam int          CNT_W   = 4;
  localparam int          OPS_W   = NUM_OPS * DATA_W;
  localparam logic [31:0] HPC     = 32'h0000_4180;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              stall = 1'b0, hold = 1'b0, flush = 1'b0;
  logic              d_valid = 1'b0;
  logic [DATA_W-1:0] d_instr = '0;
  logic [PC_W-1:0]   d_pc = '0;
  logic [OPS_W-1:0]  d_ops = '0;
  logic [EXC_W-1:0]  d_exc = '0;
  logic              d_bd = 1'b0;
  logic              q_valid;
  logic [DATA_W-1:0] q_instr;
  logic [PC_W-1:0]   q_pc;
  logic [OPS_W-1:0]  q_ops;
  logic [EXC_W-1:0]  q_exc;
  logic              q_bd;
  logic [CNT_W-1:0]  bubble_cnt, flush_cnt;

  pipe_stage_reg #(
    .DATA_W (DATA_W), .PC_W (PC_W), .NUM_OPS (NUM_OPS), .EXC_W (EXC_W),
    .HANDLER_PC (HPC), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .reset (reset), .stall (stall), .hold (hold), .flush (flush),
    .d_valid (d_valid), .d_instr (d_instr), .d_pc (d_pc), .d_ops (d_ops),
    .d_exc (d_exc), .d_bd (d_bd),
    .q_valid (q_valid), .q_instr (q_instr), .q_pc (q_pc), .q_ops (q_ops),
    .q_exc (q_exc), .q_bd (q_bd),
    .bubble_cnt (bubble_cnt), .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             valid;
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [OPS_W-1:0] ops;
    logic [4:0]       exc;
    logic             bd;
    int               bcnt;
    int               fcnt;
  } slot_t;

  slot_t m;          // model state
  slot_t sb[$];      // expected slots, one per edge
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [OPS_W-1:0] act,
                     input logic [OPS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_slot(input string tag, input slot_t e);
    chk({tag, ".valid"}, OPS_W'(q_valid), OPS_W'(e.valid));
    chk({tag, ".instr"}, OPS_W'(q_instr), OPS_W'(e.instr));
    chk({tag, ".pc"},    OPS_W'(q_pc),    OPS_W'(e.pc));
    chk({tag, ".ops"},   q_ops,           e.ops);
    chk({tag, ".exc"},   OPS_W'(q_exc),   OPS_W'(e.exc));
    chk({tag, ".bd"},    OPS_W'(q_bd),    OPS_W'(e.bd));
    chk({tag, ".bcnt"},  OPS_W'(bubble_cnt), OPS_W'(e.bcnt));
    chk({tag, ".fcnt"},  OPS_W'(flush_cnt),  OPS_W'(e.fcnt));
  endtask

  function automatic void model_reset();
    m.valid = 1'b0; m.instr = '0; m.pc = '0; m.ops = '0;
    m.exc = '0; m.bd = 1'b0; m.bcnt = 0; m.fcnt = 0;
  endfunction

  // Monitor: registered outputs settle after the edge, so sample 1 unit later
  initial begin
    slot_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare_slot("edge", e);
      end
    end
  end

  // Drive one edge's inputs and queue the slot the rules say must result
  task automatic step(input logic f, input logic h, input logic s,
                      input logic v, input logic [31:0] instr,
                      input logic [31:0] pc, input logic [OPS_W-1:0] ops,
                      input logic [4:0] exc, input logic bd);
    @(negedge clk);
    flush = f; hold = h; stall = s; d_valid = v; d_instr = instr;
    d_pc = pc; d_ops = ops; d_exc = exc; d_bd = bd;
    if (f) begin
      m.valid = 1'b0; m.instr = '0; m.ops = '0; m.exc = '0; m.bd = 1'b0;
      m.pc = HPC;
`ifdef PIPE_STAGE_PERF_CNT_EN
      if (m.fcnt < CNT_MAX) m.fcnt++;
`endif
    end else if (h) begin
      // frozen: nothing changes
    end else if (s) begin
      m.valid = 1'b0; m.instr = '0; m.ops = '0; m.exc = '0;
      m.pc = pc; m.bd = bd;
`ifdef PIPE_STAGE_PERF_CNT_EN
      if (m.bcnt < CNT_MAX) m.bcnt++;
`endif
    end else begin
      m.valid = v; m.pc = pc; m.bd = bd; m.exc = exc; m.ops = ops;
      m.instr = (exc == 5'd0) ? instr : 32'h0;
    end
    sb.push_back(m);
  endtask

  // Assert reset in the middle of the low phase and check it acts at once
  task automatic async_reset();
    slot_t z;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    z = m;
    compare_slot("async_rst", z);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  function automatic logic [OPS_W-1:0] rand_ops();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    slot_t z;
    model_reset();
    #12;
    z = m;
    compare_slot("reset", z);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // First load after reset
    step(0, 0, 0, 1, 32'h3421_0005, 32'h3000, 96'h1_0000_0002_0000_0003, 0, 0);
    step(0, 0, 0, 1, 32'h2402_0007, 32'h3004, rand_ops(), 0, 1);
    // Reset while loaded
    async_reset();
    step(0, 0, 0, 1, 32'h3421_0005, 32'h3000, rand_ops(), 0, 0);
    // Stall bubble keeps PC and BD
    step(0, 0, 1, 1, 32'h1000_0003, 32'h3008, rand_ops(), 0, 1);
    // Flush beats hold and stall
    step(0, 0, 0, 1, 32'h8C43_0010, 32'h300C, rand_ops(), 5'd4, 1);
    step(1, 1, 1, 1, 32'h1234_5678, 32'h300C, rand_ops(), 5'd12, 1);
    // Hold for 3 edges, with stall present on one of them
    step(0, 0, 0, 1, 32'h0043_2020, 32'h4180, rand_ops(), 0, 0);
    step(0, 1, 0, 1, 32'hDEAD_BEEF, 32'h5000, rand_ops(), 0, 1);
    step(0, 1, 1, 1, 32'hDEAD_BEEF, 32'h5004, rand_ops(), 0, 1);
    step(0, 1, 0, 0, 32'hDEAD_BEEF, 32'h5008, rand_ops(), 5'd5, 1);
    // Exception squash
    step(0, 0, 0, 1, 32'hFC00_0000, 32'h3010, rand_ops(), 5'd10, 0);
    // Invalid slot still carries the instruction
    step(0, 0, 0, 0, 32'h0109_4821, 32'h3014, rand_ops(), 0, 0);

    // Counter saturation: 20 stalls and 2 flushes from a clean reset
    async_reset();
    for (int i = 0; i < 20; i++)
      step(0, 0, 1, 1, $urandom(), 32'h6000 + 4 * i, rand_ops(), 0, i[0]);
    step(1, 0, 0, 1, $urandom(), 32'h7000, rand_ops(), 0, 0);
    step(1, 0, 1, 1, $urandom(), 32'h7004, rand_ops(), 0, 1);

    // Randomized control and data
    async_reset();
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      step(r == 0, (r == 1) || (r == 2), $urandom_range(0, 3) == 0,
           1'($urandom()), $urandom(), $urandom(), rand_ops(),
           ($urandom_range(0, 3) == 0) ? 5'($urandom()) : 5'd0,
           1'($urandom()));
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register (D→E class) for the MIPS pipeline.
- Carries the instruction, PC, N operand words, exception code and branch-delay flag, plus an explicit valid bit.
- Supports bubble insertion (stall), whole-stage freeze (hold), interrupt/exception flush with handler-PC load, and exception squash of the carried instruction.
- Instantiated once per stage boundary: D/E, E/M and M/W.

Parameters:
- DATA_W, 32, width of the instruction and of each operand word
- PC_W, 32, width of the PC field
- NUM_OPS, 2, number of operand words carried (payload = NUM_OPS*DATA_W)
- EXC_W, 5, exception code width (0 = no exception)
- HANDLER_PC, 32'h0000_4180, PC loaded on flush
- CNT_W, 16, width of the performance counters (optional feature)

Ports:
- clk, input, 1, clock, rising edge
- reset, input, 1, asynchronous, active-low (asserted at 0)
- stall, input, 1, insert a bubble this cycle
- hold, input, 1, freeze the stage (downstream busy, e.g. MDU)
- flush, input, 1, interrupt/exception flush
- d_valid, input, 1, upstream slot is valid
- d_instr, input, DATA_W, upstream instruction
- d_pc, input, PC_W, upstream PC
- d_ops, input, NUM_OPS*DATA_W, upstream operands; op k = bits [k*DATA_W +: DATA_W]
- d_exc, input, EXC_W, upstream exception code
- d_bd, input, 1, upstream branch-delay flag
- q_valid, output, 1, registered valid
- q_instr, output, DATA_W, registered instruction
- q_pc, output, PC_W, registered PC
- q_ops, output, NUM_OPS*DATA_W, registered operands
- q_exc, output, EXC_W, registered exception code
- q_bd, output, 1, registered branch-delay flag
- bubble_cnt, output, CNT_W, stall-bubble count (0 unless feature enabled)
- flush_cnt, output, CNT_W, flush count (0 unless feature enabled)

Behaviour:
- All outputs are registers and update on the rising edge of clk. Latency is 1 cycle.
- reset=0 forces, asynchronously:
  - all q_* to 0, except q_pc = 0
  - both counters to 0
- Per-edge priority: flush > hold > stall > load.
- flush:
  - q_valid=0, q_instr=0, q_ops=0, q_exc=0, q_bd=0
  - q_pc=HANDLER_PC
  - flush overrides hold; a frozen stage is still flushed.
- hold (flush=0): every register retains its value. stall is ignored, so no bubble is inserted while frozen.
- stall (flush=0, hold=0): bubble.
  - q_valid=0, q_instr=0, q_ops=0, q_exc=0
  - q_pc=d_pc and q_bd=d_bd, so that an EPC computed for the bubble is correct.
- load (none of flush/hold/stall):
  - q_valid=d_valid
  - q_pc=d_pc, q_bd=d_bd, q_exc=d_exc, q_ops=d_ops
  - q_instr = d_instr if d_exc==0, else 0 (squash: a faulting instruction must not execute downstream; the exception code and PC still travel).
- d_valid=0 on load: q_instr = d_instr unchanged. Consumers gate on q_valid.
- A simultaneous stall+hold produces no bubble and no count.
- A reset during any operation takes effect immediately. After release, the first edge follows normal priority.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- Defined:
  - bubble_cnt increments on each edge where a stall bubble is actually inserted.
  - flush_cnt increments on each edge with flush=1.
  - Both saturate at 2^CNT_W-1 (no wrap) and clear only on reset.
- Undefined: both outputs are constant 0 and no counter flops are inferred.

Decomposition:
- Package pipe_pkg holds:
  - HANDLER_PC default 32'h0000_4180
  - EXC_W default 5
  - NOP encoding 32'h0
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12
  - priority-select typedef {SEL_FLUSH, SEL_HOLD, SEL_STALL, SEL_LOAD}
- One sub-module, pipe_perf_cnt: saturating CNT_W counter with enable and async active-low reset, instantiated twice under the macro.

Test Plan:
- Reset: drive reset=0 mid-cycle with q_* loaded → all outputs 0 immediately, without waiting for a clock edge. Release, then load d_instr=32'h3421_0005, d_pc=32'h3000 → q_instr=32'h3421_0005, q_pc=32'h3000, q_valid=1 after 1 edge.
- Stall bubble: stall=1, d_pc=32'h3008, d_bd=1, d_instr=32'h1000_0003 → q_instr=0, q_valid=0, q_pc=32'h3008, q_bd=1, q_ops=0.
- Flush vs hold: flush=1, hold=1, stall=1 → q_pc=32'h0000_4180, q_valid=0, q_bd=0, q_exc=0. With hold=1 alone for 3 edges → q_* unchanged and bubble_cnt unchanged.
- Exception squash: d_exc=5'd10, d_instr=32'hFC00_0000, d_pc=32'h3010, NUM_OPS=3 → q_instr=0, q_exc=10, q_pc=32'h3010, q_valid=1, q_ops=d_ops.
- Counters (macro defined, CNT_W=4): 20 stall edges and 2 flush edges → bubble_cnt=15 (saturated), flush_cnt=2. Macro undefined → both read 0.
